// File: rtl/data_mem_assoc_if.sv
// rtl/data_mem_assoc_if.sv - CPU access and refill signal bundle for the set-associative data array
interface data_mem_assoc_if #(
  parameter int SETS   = 256,
  parameter int WAYS   = 2,
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int BEAT_W = 64
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int WORDS = LINE_W / WORD_W;
  localparam int OFF_W = $clog2(WORDS);
  localparam int BYTES = WORD_W / 8;

  logic              cpu_req_i;
  logic              cpu_ready_o;
  logic              cpu_we_i;
  logic [IDX_W-1:0]  cpu_set_i;
  logic [WAY_W-1:0]  cpu_way_i;
  logic [OFF_W-1:0]  cpu_word_i;
  logic [BYTES-1:0]  cpu_be_i;
  logic [WORD_W-1:0] cpu_wdata_i;
  logic              rd_valid_o;
  logic [LINE_W-1:0] rd_line_o;
  logic [WORD_W-1:0] rd_word_o;
  logic              fill_start_i;
  logic [IDX_W-1:0]  fill_set_i;
  logic [WAY_W-1:0]  fill_way_i;
  logic              fill_valid_i;
  logic              fill_ready_o;
  logic [BEAT_W-1:0] fill_data_i;
  logic              fill_done_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_set_i, cpu_way_i, cpu_word_i, cpu_be_i, cpu_wdata_i,
    input  fill_start_i, fill_set_i, fill_way_i, fill_valid_i, fill_data_i,
    output cpu_ready_o, rd_valid_o, rd_line_o, rd_word_o, fill_ready_o, fill_done_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_set_i, cpu_way_i, cpu_word_i, cpu_be_i, cpu_wdata_i,
    output fill_start_i, fill_set_i, fill_way_i, fill_valid_i, fill_data_i,
    input  cpu_ready_o, rd_valid_o, rd_line_o, rd_word_o, fill_ready_o, fill_done_o
  );
endinterface

// File: rtl/data_mem_assoc.sv
// rtl/data_mem_assoc.sv - N-way set-associative L1 data array with byte-enabled writes and beat refill
module data_mem_assoc #(
  parameter int SETS   = 256,
  parameter int WAYS   = 2,
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int BEAT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  data_mem_assoc_if.slave  bus
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WORDS  = LINE_W / WORD_W;
  localparam int OFF_W  = $clog2(WORDS);
  localparam int BYTES  = WORD_W / 8;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int ADDR_W = IDX_W + WAY_W;

  typedef enum logic {ST_IDLE, ST_FILL} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  fill_set_q, fill_set_d;
  logic [WAY_W-1:0]  fill_way_q, fill_way_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              fill_done_q, fill_done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [LINE_W-1:0] rd_line_q, rd_line_d;
  logic [WORD_W-1:0] rd_word_q, rd_word_d;

  logic [LINE_W-1:0] mem_q [SETS*WAYS];

  logic              cpu_acc, beat_acc, wr_en;
  logic [ADDR_W-1:0] cpu_addr, fill_addr, wr_addr;
  logic [LINE_W-1:0] cpu_line, fill_line, wr_line;
  logic [WORD_W-1:0] cpu_word;

  assign bus.cpu_ready_o  = (state_q == ST_IDLE);
  assign bus.fill_ready_o = (state_q == ST_FILL);
  assign bus.rd_valid_o   = rd_valid_q;
  assign bus.rd_line_o    = rd_line_q;
  assign bus.rd_word_o    = rd_word_q;
  assign bus.fill_done_o  = fill_done_q;

  assign cpu_acc   = bus.cpu_req_i & bus.cpu_ready_o;
  assign beat_acc  = bus.fill_valid_i & bus.fill_ready_o;
  assign cpu_addr  = {bus.cpu_set_i, bus.cpu_way_i};
  assign fill_addr = {fill_set_q, fill_way_q};

  // Merged line doubles as the write-first read data returned next cycle.
  always_comb begin
    cpu_line = mem_q[cpu_addr];
    cpu_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (bus.cpu_word_i == OFF_W'(w)) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.cpu_we_i && bus.cpu_be_i[b]) begin
            cpu_line[w*WORD_W + b*8 +: 8] = bus.cpu_wdata_i[b*8 +: 8];
          end
        end
        cpu_word = cpu_line[w*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    fill_line = mem_q[fill_addr];
    for (int k = 0; k < BEATS; k++) begin
      if (beat_cnt_q == CNT_W'(k)) begin
        fill_line[k*BEAT_W +: BEAT_W] = bus.fill_data_i;
      end
    end
  end

  // CPU and fill writes are exclusive by state; reset suppresses any write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cpu_addr;
    wr_line = cpu_line;
    if (state_q == ST_FILL) begin
      wr_en   = rst_ni & beat_acc;
      wr_addr = fill_addr;
      wr_line = fill_line;
    end else begin
      wr_en   = rst_ni & cpu_acc & bus.cpu_we_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_set_d  = fill_set_q;
    fill_way_d  = fill_way_q;
    beat_cnt_d  = beat_cnt_q;
    fill_done_d = 1'b0;
    rd_valid_d  = cpu_acc;
    rd_line_d   = rd_line_q;
    rd_word_d   = rd_word_q;
    if (cpu_acc) begin
      rd_line_d = cpu_line;
      rd_word_d = cpu_word;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.fill_start_i) begin
          state_d    = ST_FILL;
          fill_set_d = bus.fill_set_i;
          fill_way_d = bus.fill_way_i;
          beat_cnt_d = '0;
        end
      end
      ST_FILL: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == CNT_W'(BEATS-1)) begin
            state_d     = ST_IDLE;
            beat_cnt_d  = '0;
            fill_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      fill_set_q  <= '0;
      fill_way_q  <= '0;
      beat_cnt_q  <= '0;
      fill_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_line_q   <= '0;
      rd_word_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_set_q  <= fill_set_d;
      fill_way_q  <= fill_way_d;
      beat_cnt_q  <= beat_cnt_d;
      fill_done_q <= fill_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_line_q   <= rd_line_d;
      rd_word_q   <= rd_word_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_line;
    end
  end
endmodule

// File: tb/tb_data_mem_assoc.sv
// tb/tb_data_mem_assoc.sv - scoreboard bench for data_mem_assoc (default build and 64-set 4-way build)
module tb_data_mem_assoc;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_assoc_if bus_a ();
  data_mem_assoc_if #(.SETS(64), .WAYS(4)) bus_b ();

  data_mem_assoc dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a));
  data_mem_assoc #(.SETS(64), .WAYS(4)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b));

  typedef struct {
    logic [LW-1:0] line;
    logic [31:0]   word;
    bit            chk_line;
    int            tag;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  logic [LW-1:0] sh_a [int];
  int total = 0;
  int bad = 0;
  int tag = 0;

  function automatic void chk(string nm, logic [LW-1:0] got, logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus_a.rd_valid_o === 1'b1) begin
      if (q_a.size() == 0) chk("a_unexpected_rd_valid", 1, 0);
      else begin
        e = q_a.pop_front();
        chk($sformatf("a_rd_word#%0d", e.tag), bus_a.rd_word_o, e.word);
        if (e.chk_line) chk($sformatf("a_rd_line#%0d", e.tag), bus_a.rd_line_o, e.line);
      end
    end
    if (bus_b.rd_valid_o === 1'b1) begin
      if (q_b.size() == 0) chk("b_unexpected_rd_valid", 1, 0);
      else begin
        e = q_b.pop_front();
        chk($sformatf("b_rd_word#%0d", e.tag), bus_b.rd_word_o, e.word);
        if (e.chk_line) chk($sformatf("b_rd_line#%0d", e.tag), bus_b.rd_line_o, e.line);
      end
    end
    if (rst_n) chk("a_done_with_valid", bus_a.rd_valid_o & bus_a.fill_done_o, 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_a(input bit we, input int set, input int way, input int word,
                       input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp_word);
    exp_t e;
    logic [LW-1:0] l;
    int key;
    key = set*2 + way;
    l = sh_a[key];
    if (we) for (int b = 0; b < 4; b++) if (be[b]) l[word*32 + b*8 +: 8] = wd[b*8 +: 8];
    sh_a[key] = l;
    bus_a.cpu_req_i = 1'b1; bus_a.cpu_we_i = we;
    bus_a.cpu_set_i = 8'(set); bus_a.cpu_way_i = 1'(way); bus_a.cpu_word_i = 3'(word);
    bus_a.cpu_be_i = be; bus_a.cpu_wdata_i = wd;
    e.line = l; e.word = exp_word; e.chk_line = 1'b1; e.tag = tag++;
    q_a.push_back(e);
    chk("a_cpu_ready", bus_a.cpu_ready_o, 1);
    cyc();
    bus_a.cpu_req_i = 1'b0;
  endtask

  task automatic cpu_b(input bit we, input int set, input int way, input int word,
                       input logic [31:0] wd, input logic [31:0] exp_word,
                       input logic [LW-1:0] exp_line, input bit chk_line);
    exp_t e;
    bus_b.cpu_req_i = 1'b1; bus_b.cpu_we_i = we;
    bus_b.cpu_set_i = 6'(set); bus_b.cpu_way_i = 2'(way); bus_b.cpu_word_i = 3'(word);
    bus_b.cpu_be_i = 4'hF; bus_b.cpu_wdata_i = wd;
    e.line = exp_line; e.word = exp_word; e.chk_line = chk_line; e.tag = tag++;
    q_b.push_back(e);
    chk("b_cpu_ready", bus_b.cpu_ready_o, 1);
    cyc();
  endtask

  task automatic fill_start_a(input int set, input int way);
    bus_a.fill_start_i = 1'b1; bus_a.fill_set_i = 8'(set); bus_a.fill_way_i = 1'(way);
    cyc();
    bus_a.fill_start_i = 1'b0;
  endtask

  task automatic fill_beats_a(input int set, input int way, input logic [63:0] b [4],
                              input int gap_after, input int nbeats, output int rdy);
    logic [LW-1:0] l;
    int key;
    key = set*2 + way;
    l = sh_a.exists(key) ? sh_a[key] : {LW{1'bx}};
    rdy = 0;
    for (int k = 0; k < nbeats; k++) begin
      if (gap_after >= 0 && k == gap_after + 1) begin
        bus_a.fill_valid_i = 1'b0;
        if (bus_a.fill_ready_o) rdy++;
        cyc();
      end
      bus_a.fill_valid_i = 1'b1; bus_a.fill_data_i = b[k];
      if (bus_a.fill_ready_o) rdy++;
      l[k*64 +: 64] = b[k];
      cyc();
    end
    bus_a.fill_valid_i = 1'b0;
    sh_a[key] = l;
  endtask

  task automatic check_done_a();
    chk("a_fill_done_pulse", bus_a.fill_done_o, 1);
    chk("a_fill_ready_after", bus_a.fill_ready_o, 0);
    chk("a_cpu_ready_after", bus_a.cpu_ready_o, 1);
    cyc();
    chk("a_fill_done_clear", bus_a.fill_done_o, 0);
  endtask

  task automatic fill_a(input int set, input int way, input logic [63:0] b [4], input int gap_after);
    int rdy;
    fill_start_a(set, way);
    fill_beats_a(set, way, b, gap_after, 4, rdy);
    chk("a_fill_ready_cycles", rdy, (gap_after >= 0) ? 5 : 4);
    check_done_a();
  endtask

  logic [63:0] bb [4];
  logic [LW-1:0] ln;
  int rdy;

  initial begin
    bus_a.cpu_req_i = 0; bus_a.cpu_we_i = 0; bus_a.cpu_set_i = 0; bus_a.cpu_way_i = 0;
    bus_a.cpu_word_i = 0; bus_a.cpu_be_i = 0; bus_a.cpu_wdata_i = 0; bus_a.fill_start_i = 0;
    bus_a.fill_set_i = 0; bus_a.fill_way_i = 0; bus_a.fill_valid_i = 0; bus_a.fill_data_i = 0;
    bus_b.cpu_req_i = 0; bus_b.cpu_we_i = 0; bus_b.cpu_set_i = 0; bus_b.cpu_way_i = 0;
    bus_b.cpu_word_i = 0; bus_b.cpu_be_i = 0; bus_b.cpu_wdata_i = 0; bus_b.fill_start_i = 0;
    bus_b.fill_set_i = 0; bus_b.fill_way_i = 0; bus_b.fill_valid_i = 0; bus_b.fill_data_i = 0;
    cyc(); cyc();
    rst_n = 1'b1;
    chk("a_rst_cpu_ready", bus_a.cpu_ready_o, 1);
    chk("a_rst_fill_ready", bus_a.fill_ready_o, 0);
    chk("a_rst_fill_done", bus_a.fill_done_o, 0);
    chk("a_rst_rd_valid", bus_a.rd_valid_o, 0);
    chk("a_rst_rd_word", bus_a.rd_word_o, 0);
    chk("a_rst_rd_line", bus_a.rd_line_o, 0);
    chk("b_rst_cpu_ready", bus_b.cpu_ready_o, 1);

    // known background contents for set 5: word n = 5w00_000n
    bb = '{64'h5000_0001_5000_0000, 64'h5000_0003_5000_0002,
           64'h5000_0005_5000_0004, 64'h5000_0007_5000_0006};
    fill_a(5, 0, bb, -1);
    bb = '{64'h5100_0001_5100_0000, 64'h5100_0003_5100_0002,
           64'h5100_0005_5100_0004, 64'h5100_0007_5100_0006};
    fill_a(5, 1, bb, -1);

    // full and partial byte-enabled writes, no-op write, neighbour way untouched
    cpu_a(1, 5, 1, 3, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF);
    cpu_a(0, 5, 0, 3, 4'h0, 32'h0, 32'h5000_0003);
    cpu_a(0, 5, 1, 2, 4'h0, 32'h0, 32'h5100_0002);
    cpu_a(1, 5, 1, 3, 4'b0101, 32'h11223344, 32'hDE22BE44);
    cpu_a(1, 5, 1, 3, 4'b0000, 32'hFFFFFFFF, 32'hDE22BE44);
    cpu_a(0, 5, 1, 3, 4'h0, 32'h0, 32'hDE22BE44);
    cyc();
    chk("a_hold_rd_valid", bus_a.rd_valid_o, 0);
    chk("a_hold_rd_word", bus_a.rd_word_o, 32'hDE22BE44);

    // refill with a stall after beat 1
    bb = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    fill_a(9, 0, bb, 1);
    cpu_a(0, 9, 0, 0, 4'h0, 32'h0, 32'h0000_00A0);
    cpu_a(0, 9, 0, 6, 4'h0, 32'h0, 32'h0000_00A3);

    // CPU request during FILL is dropped
    bb = '{64'hE0, 64'hE1, 64'hE2, 64'hE3};
    fill_start_a(12, 1);
    bus_a.cpu_req_i = 1'b1; bus_a.cpu_we_i = 1'b1; bus_a.cpu_set_i = 8'd5; bus_a.cpu_way_i = 1'b1;
    bus_a.cpu_word_i = 3'd3; bus_a.cpu_be_i = 4'hF; bus_a.cpu_wdata_i = 32'h0;
    chk("a_busy_cpu_ready", bus_a.cpu_ready_o, 0);
    chk("a_busy_fill_ready", bus_a.fill_ready_o, 1);
    cyc();
    chk("a_busy_no_rd_valid", bus_a.rd_valid_o, 0);
    bus_a.cpu_req_i = 1'b0;
    fill_beats_a(12, 1, bb, -1, 4, rdy);
    check_done_a();
    cpu_a(0, 5, 1, 3, 4'h0, 32'h0, 32'hDE22BE44);

    // simultaneous fill_start and CPU read in IDLE
    bus_a.fill_start_i = 1'b1; bus_a.fill_set_i = 8'd20; bus_a.fill_way_i = 1'b1;
    cpu_a(0, 9, 0, 2, 4'h0, 32'h0, 32'h0000_00A1);
    bus_a.fill_start_i = 1'b0;
    chk("a_start_req_fill_ready", bus_a.fill_ready_o, 1);
    chk("a_start_req_cpu_ready", bus_a.cpu_ready_o, 0);
    bb = '{64'hB0B0_0001_B0B0_0000, 64'hB1B1_0003_B1B1_0002,
           64'hB2B2_0005_B2B2_0004, 64'hB3B3_0007_B3B3_0006};
    fill_beats_a(20, 1, bb, -1, 4, rdy);
    check_done_a();
    cpu_a(0, 20, 1, 7, 4'h0, 32'h0, 32'hB3B3_0007);
    cpu_a(0, 20, 1, 4, 4'h0, 32'h0, 32'hB2B2_0004);

    // reset after two beats of a refill
    bb = '{64'hC0C0_0001_C0C0_0000, 64'hC0C0_0003_C0C0_0002,
           64'hC0C0_0005_C0C0_0004, 64'hC0C0_0007_C0C0_0006};
    fill_a(30, 0, bb, -1);
    bb = '{64'hD0D0_0001_D0D0_0000, 64'hD0D0_0003_D0D0_0002, 64'h0, 64'h0};
    fill_start_a(30, 0);
    fill_beats_a(30, 0, bb, -1, 2, rdy);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("a_midrst_cpu_ready", bus_a.cpu_ready_o, 1);
    chk("a_midrst_fill_ready", bus_a.fill_ready_o, 0);
    chk("a_midrst_fill_done", bus_a.fill_done_o, 0);
    cyc();
    chk("a_midrst_fill_done2", bus_a.fill_done_o, 0);
    cpu_a(0, 30, 0, 1, 4'h0, 32'h0, 32'hD0D0_0001);
    cpu_a(0, 30, 0, 2, 4'h0, 32'h0, 32'hD0D0_0002);
    cpu_a(0, 30, 0, 5, 4'h0, 32'h0, 32'hC0C0_0005);

    // 64-set 4-way build: back-to-back writes then reads across all ways of two aliasing-prone sets
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 4; w++)
        for (int k = 0; k < 8; k++)
          cpu_b(1, 7 + 32*s, w, k, {8'(7 + 32*s), 4'(w), 4'(k), 16'hC0DE},
                {8'(7 + 32*s), 4'(w), 4'(k), 16'hC0DE}, '0, 1'b0);
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 4; w++) begin
        for (int k = 0; k < 8; k++) ln[k*32 +: 32] = {8'(7 + 32*s), 4'(w), 4'(k), 16'hC0DE};
        for (int k = 0; k < 8; k++)
          cpu_b(0, 7 + 32*s, w, k, 32'h0, {8'(7 + 32*s), 4'(w), 4'(k), 16'hC0DE}, ln, 1'b1);
      end
    bus_b.cpu_req_i = 1'b0;

    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) cyc();
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
